// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller. Detects load-use and branch operand
//             hazards, squashes the wrong-path instruction after a taken
//             branch, honours an external freeze and counts bubble cycles.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_hold,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic        id_equal,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dst,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dst,
    input  logic        cnt_clear,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        pc_src,
    output logic        id_kill,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_stall_cnt;
    logic        w_dep_ex;
    logic        w_dep_mem;
    logic        w_h2;
    logic        w_h1;

    // A producer register matches a source of the ID instruction; r0 never does.
    function automatic logic f_dep(input logic [4:0] x, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
        f_dep = (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

    // Hazard classification: H2 needs two bubbles, H1 needs one.
    always_comb begin
        w_dep_ex  = f_dep(ex_dst,  id_rs, id_rt, id_uses_rt);
        w_dep_mem = f_dep(mem_dst, id_rs, id_rt, id_uses_rt);
        w_h2 = id_is_branch & ex_mem_read & w_dep_ex;
        w_h1 = (id_is_branch & ex_reg_write & ~ex_mem_read & w_dep_ex)
             | (id_is_branch & mem_mem_read & w_dep_mem)
             | (~id_is_branch & ex_mem_read & w_dep_ex);
    end

    // State register; reset abandons any STALL/FLUSH sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and zero-latency control outputs; reset, then hold, take priority.
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        pc_src       = 1'b0;
        id_kill      = (r_state == ST_FLUSH);

        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            id_kill      = 1'b0;
            w_next_state = ST_RUN;
        end else if (ext_hold) begin
            // Freeze everything but do not inject a bubble.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_h2) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_bubble  = 1'b1;
                        w_next_state = ST_STALL;
                    end else if (w_h1) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_bubble  = 1'b1;
                    end else if (id_is_branch && id_equal) begin
                        pc_src       = 1'b1;
                        w_next_state = ST_FLUSH;
                    end
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_bubble  = 1'b1;
                    w_next_state = ST_RUN;
                end
                ST_FLUSH: begin
                    w_next_state = ST_RUN;
                end
                default: begin
                    // Unreachable encoding: bubble once and recover.
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_bubble  = 1'b1;
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // Saturating bubble counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clear) begin
            r_stall_cnt <= 16'd0;
        end else if (idex_bubble && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
